// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-channel memory command arbiter with read-tag routing.
//
// Each channel i issues commands tagged with id i+1. One channel is granted per
// cycle, chosen by fixed priority (RR=0) or round-robin (RR=1). Its command is
// forwarded combinationally to the memory port. A command stalled by
// mem_waitrequest locks the grant until it is accepted. Accepted reads are
// counted as outstanding until a tagged return arrives. New reads are held off
// while MAX_OUT reads are in flight. Writes are never held off.
//
// Ports:
//   clock, rst              sole clock, asynchronous active-high reset
//   ch_read/ch_write        per-channel command strobes (write wins if both)
//   ch_address              per-channel word address, slice i = channel i
//   ch_writedata/mask       per-channel write data and byte mask
//   ch_waitrequest          per-channel stall (1 for every non-granted channel)
//   ch_readdata             shared read-return data
//   ch_readdatavalid        per-channel read-return strobe, decoded from the tag
//   mem_waitrequest         memory stall
//   mem_id/address/read/write/writedata/writedatamask   granted command
//   mem_readdata/readdataid returned data and its tag (0 = no return)
//   outstanding             current number of reads in flight
module mem_arbiter_n #(
   parameter int unsigned N       = 2,
   parameter int unsigned AW      = 30,
   parameter int unsigned DW      = 32,
   parameter int unsigned IDW     = 3,
   parameter int unsigned RR      = 0,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [N-1:0]          ch_read,
   input  logic [N-1:0]          ch_write,
   input  logic [N*AW-1:0]       ch_address,
   input  logic [N*DW-1:0]       ch_writedata,
   input  logic [N*(DW/8)-1:0]   ch_writedatamask,
   output logic [N-1:0]          ch_waitrequest,
   output logic [DW-1:0]         ch_readdata,
   output logic [N-1:0]          ch_readdatavalid,
   input  logic                  mem_waitrequest,
   output logic [IDW-1:0]        mem_id,
   output logic [AW-1:0]         mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DW-1:0]         mem_writedata,
   output logic [DW/8-1:0]       mem_writedatamask,
   input  logic [DW-1:0]         mem_readdata,
   input  logic [IDW-1:0]        mem_readdataid,
   output logic [3:0]            outstanding
);

   localparam int unsigned MW = DW / 8;
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   typedef logic [PW-1:0] idx_t;

   typedef enum logic {
      StFree,
      StLocked
   } lock_state_e;

   // State
   lock_state_e lock_state_q, lock_state_d;
   idx_t        lock_ch_q, lock_ch_d;
   idx_t        rr_ptr_q, rr_ptr_d;
   logic [3:0]  outstanding_q, outstanding_d;

   // Arbitration
   logic         read_full;
   logic [N-1:0] eligible;
   logic         pick_valid;
   idx_t         pick_idx;
   logic         hi_valid;
   idx_t         hi_idx;
   logic         lo_valid;
   idx_t         lo_idx;
   logic         grant_valid;
   idx_t         grant_idx;

   // Handshake and return
   logic         accept;
   logic         rd_accept;
   logic         ret_valid;
   logic         ret_dec;

   assign read_full = (outstanding_q == 4'(MAX_OUT));
   assign eligible  = ch_write | (ch_read & {N{~read_full}});

   // Candidate selection. Round-robin is split into two lowest-index searches:
   // first among channels at or above rr_ptr, then over all channels, which is
   // the same as a wrapping search starting at rr_ptr.
   always_comb begin
      hi_valid   = 1'b0;
      hi_idx     = '0;
      lo_valid   = 1'b0;
      lo_idx     = '0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            lo_valid = 1'b1;
            lo_idx   = idx_t'(i);
            if (idx_t'(i) >= rr_ptr_q) begin
               hi_valid = 1'b1;
               hi_idx   = idx_t'(i);
            end
         end
      end
      if (RR != 0) begin
         pick_valid = hi_valid | lo_valid;
         pick_idx   = hi_valid ? hi_idx : lo_idx;
      end else begin
         pick_valid = lo_valid;
         pick_idx   = lo_idx;
      end
   end

   // A locked channel keeps the grant regardless of priority or read limit.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      if (rst) begin
         grant_valid = 1'b0;
      end else if (lock_state_q == StLocked) begin
         grant_valid = 1'b1;
         grant_idx   = lock_ch_q;
      end else begin
         grant_valid = pick_valid;
         grant_idx   = pick_idx;
      end
   end

   // Command mux, zero-cycle path from the granted channel to the memory port.
   always_comb begin
      mem_id            = '0;
      mem_address       = '0;
      mem_read          = 1'b0;
      mem_write         = 1'b0;
      mem_writedata     = '0;
      mem_writedatamask = '0;
      ch_waitrequest    = '1;
      for (int i = 0; i < N; i++) begin
         if (grant_valid && (grant_idx == idx_t'(i))) begin
            mem_id            = IDW'(i + 1);
            mem_address       = ch_address[i*AW +: AW];
            mem_writedata     = ch_writedata[i*DW +: DW];
            mem_writedatamask = ch_writedatamask[i*MW +: MW];
            mem_write         = ch_write[i];
            mem_read          = ch_read[i] & ~ch_write[i];
            ch_waitrequest[i] = mem_waitrequest;
         end
      end
   end

   assign accept    = grant_valid & ~mem_waitrequest;
   assign rd_accept = accept & mem_read;

   // Return routing. Tags above N decode to nothing and leave the count alone.
   always_comb begin
      ch_readdatavalid = '0;
      for (int i = 0; i < N; i++) begin
         ch_readdatavalid[i] = (mem_readdataid == IDW'(i + 1));
      end
   end

   assign ret_valid   = |ch_readdatavalid;
   // A return with nothing in flight (e.g. after a reset) must not underflow.
   assign ret_dec     = ret_valid & (outstanding_q != 4'd0);
   assign ch_readdata = mem_readdata;
   assign outstanding = outstanding_q;

   // Next-state logic
   always_comb begin
      lock_state_d  = StFree;
      lock_ch_d     = lock_ch_q;
      rr_ptr_d      = rr_ptr_q;
      outstanding_d = outstanding_q;

      if (grant_valid && mem_waitrequest) begin
         lock_state_d = StLocked;
         lock_ch_d    = grant_idx;
      end

      if ((RR != 0) && accept) begin
         rr_ptr_d = (grant_idx == idx_t'(N - 1)) ? '0 : grant_idx + idx_t'(1);
      end

      if (rd_accept && !ret_dec) begin
         outstanding_d = outstanding_q + 4'd1;
      end else if (!rd_accept && ret_dec) begin
         outstanding_d = outstanding_q - 4'd1;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         lock_state_q  <= StFree;
         lock_ch_q     <= '0;
         rr_ptr_q      <= '0;
         outstanding_q <= '0;
      end else begin
         lock_state_q  <= lock_state_d;
         lock_ch_q     <= lock_ch_d;
         rr_ptr_q      <= rr_ptr_d;
         outstanding_q <= outstanding_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n. Two instances are driven one at a time:
//   dut 0: N=2, fixed priority, MAX_OUT=2
//   dut 1: N=3, round-robin,    MAX_OUT=4
// A per-cycle reference model (grant choice, lock, pointer, read count kept as
// plain integers) predicts every output. Directed sequences and random traffic
// both go through it.
module tb_mem_arbiter_n;

   localparam int AW  = 30;
   localparam int DW  = 32;
   localparam int IDW = 3;
   localparam int MW  = DW / 8;
   localparam int NA  = 2;
   localparam int NB  = 3;

   logic clock = 1'b0;
   logic rst;
   always #5 clock = ~clock;

   // Stimulus storage, index [dut][channel]
   bit [7:0]    cur_rd    [2];
   bit [7:0]    cur_wr    [2];
   bit [AW-1:0] cur_addr  [2][8];
   bit [DW-1:0] cur_wdata [2][8];
   bit [MW-1:0] cur_mask  [2][8];
   bit          cur_wait  [2];
   bit [2:0]    cur_rid   [2];
   bit [DW-1:0] cur_rdata [2];

   // Observed outputs, normalised across both instances
   logic          obs_mrd   [2];
   logic          obs_mwr   [2];
   logic [7:0]    obs_id    [2];
   logic [7:0]    obs_wait  [2];
   logic [7:0]    obs_rv    [2];
   logic [AW-1:0] obs_addr  [2];
   logic [DW-1:0] obs_wdata [2];
   logic [MW-1:0] obs_mask  [2];
   logic [DW-1:0] obs_rdata [2];
   logic [3:0]    obs_outs  [2];

   // Reference model state and configuration
   int m_lock [2];
   int m_ptr  [2];
   int m_out  [2];
   int cfg_n   [2] = '{NA, NB};
   bit cfg_rr  [2] = '{1'b0, 1'b1};
   int cfg_max [2] = '{2, 4};

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- DUT 0 ----------------
   logic [NA-1:0]    a_rd, a_wr, a_chwait, a_rvalid;
   logic [NA*AW-1:0] a_addr;
   logic [NA*DW-1:0] a_wdata;
   logic [NA*MW-1:0] a_mask;
   logic [DW-1:0]    a_chrdata, a_mwdata, a_mrdata;
   logic             a_mwait, a_mrd, a_mwr;
   logic [IDW-1:0]   a_mid, a_rid;
   logic [AW-1:0]    a_maddr;
   logic [MW-1:0]    a_mmask;
   logic [3:0]       a_outs;

   assign a_rd     = cur_rd[0][NA-1:0];
   assign a_wr     = cur_wr[0][NA-1:0];
   assign a_mwait  = cur_wait[0];
   assign a_rid    = cur_rid[0];
   assign a_mrdata = cur_rdata[0];
   for (genvar i = 0; i < NA; i++) begin : g_a_in
      assign a_addr[i*AW +: AW]  = cur_addr[0][i];
      assign a_wdata[i*DW +: DW] = cur_wdata[0][i];
      assign a_mask[i*MW +: MW]  = cur_mask[0][i];
   end

   mem_arbiter_n #(
      .N(NA), .AW(AW), .DW(DW), .IDW(IDW), .RR(0), .MAX_OUT(2)
   ) u_dut_a (
      .clock             (clock),
      .rst               (rst),
      .ch_read           (a_rd),
      .ch_write          (a_wr),
      .ch_address        (a_addr),
      .ch_writedata      (a_wdata),
      .ch_writedatamask  (a_mask),
      .ch_waitrequest    (a_chwait),
      .ch_readdata       (a_chrdata),
      .ch_readdatavalid  (a_rvalid),
      .mem_waitrequest   (a_mwait),
      .mem_id            (a_mid),
      .mem_address       (a_maddr),
      .mem_read          (a_mrd),
      .mem_write         (a_mwr),
      .mem_writedata     (a_mwdata),
      .mem_writedatamask (a_mmask),
      .mem_readdata      (a_mrdata),
      .mem_readdataid    (a_rid),
      .outstanding       (a_outs)
   );

   // ---------------- DUT 1 ----------------
   logic [NB-1:0]    b_rd, b_wr, b_chwait, b_rvalid;
   logic [NB*AW-1:0] b_addr;
   logic [NB*DW-1:0] b_wdata;
   logic [NB*MW-1:0] b_mask;
   logic [DW-1:0]    b_chrdata, b_mwdata, b_mrdata;
   logic             b_mwait, b_mrd, b_mwr;
   logic [IDW-1:0]   b_mid, b_rid;
   logic [AW-1:0]    b_maddr;
   logic [MW-1:0]    b_mmask;
   logic [3:0]       b_outs;

   assign b_rd     = cur_rd[1][NB-1:0];
   assign b_wr     = cur_wr[1][NB-1:0];
   assign b_mwait  = cur_wait[1];
   assign b_rid    = cur_rid[1];
   assign b_mrdata = cur_rdata[1];
   for (genvar i = 0; i < NB; i++) begin : g_b_in
      assign b_addr[i*AW +: AW]  = cur_addr[1][i];
      assign b_wdata[i*DW +: DW] = cur_wdata[1][i];
      assign b_mask[i*MW +: MW]  = cur_mask[1][i];
   end

   mem_arbiter_n #(
      .N(NB), .AW(AW), .DW(DW), .IDW(IDW), .RR(1), .MAX_OUT(4)
   ) u_dut_b (
      .clock             (clock),
      .rst               (rst),
      .ch_read           (b_rd),
      .ch_write          (b_wr),
      .ch_address        (b_addr),
      .ch_writedata      (b_wdata),
      .ch_writedatamask  (b_mask),
      .ch_waitrequest    (b_chwait),
      .ch_readdata       (b_chrdata),
      .ch_readdatavalid  (b_rvalid),
      .mem_waitrequest   (b_mwait),
      .mem_id            (b_mid),
      .mem_address       (b_maddr),
      .mem_read          (b_mrd),
      .mem_write         (b_mwr),
      .mem_writedata     (b_mwdata),
      .mem_writedatamask (b_mmask),
      .mem_readdata      (b_mrdata),
      .mem_readdataid    (b_rid),
      .outstanding       (b_outs)
   );

   assign obs_mrd[0]   = a_mrd;
   assign obs_mwr[0]   = a_mwr;
   assign obs_id[0]    = 8'(a_mid);
   assign obs_wait[0]  = 8'(a_chwait);
   assign obs_rv[0]    = 8'(a_rvalid);
   assign obs_addr[0]  = a_maddr;
   assign obs_wdata[0] = a_mwdata;
   assign obs_mask[0]  = a_mmask;
   assign obs_rdata[0] = a_chrdata;
   assign obs_outs[0]  = a_outs;
   assign obs_mrd[1]   = b_mrd;
   assign obs_mwr[1]   = b_mwr;
   assign obs_id[1]    = 8'(b_mid);
   assign obs_wait[1]  = 8'(b_chwait);
   assign obs_rv[1]    = 8'(b_rvalid);
   assign obs_addr[1]  = b_maddr;
   assign obs_wdata[1] = b_mwdata;
   assign obs_mask[1]  = b_mmask;
   assign obs_rdata[1] = b_chrdata;
   assign obs_outs[1]  = b_outs;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Grant chosen by the rules: a lock wins outright; otherwise search the
   // channels in priority order for a writer or a read that is under the limit.
   function automatic int ref_grant(input int d);
      int i;
      if (m_lock[d] >= 0) return m_lock[d];
      for (int k = 0; k < cfg_n[d]; k++) begin
         i = cfg_rr[d] ? (m_ptr[d] + k) % cfg_n[d] : k;
         if (cur_wr[d][i] || (cur_rd[d][i] && m_out[d] < cfg_max[d])) return i;
      end
      return -1;
   endfunction

   function automatic bit [7:0] all_ones(input int n);
      return 8'((1 << n) - 1);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_lock[d] = -1;
         m_ptr[d]  = 0;
         m_out[d]  = 0;
      end
   endtask

   task automatic clear_inputs();
      for (int d = 0; d < 2; d++) begin
         cur_rd[d]    = '0;
         cur_wr[d]    = '0;
         cur_wait[d]  = 1'b0;
         cur_rid[d]   = '0;
         cur_rdata[d] = '0;
      end
   endtask

   task automatic check_idle(input int d);
      string p = d ? "b" : "a";
      check_eq({p, "_rst_mem_read"}, obs_mrd[d], 0);
      check_eq({p, "_rst_mem_write"}, obs_mwr[d], 0);
      check_eq({p, "_rst_mem_id"}, obs_id[d], 0);
      check_eq({p, "_rst_ch_wait"}, obs_wait[d], all_ones(cfg_n[d]));
      check_eq({p, "_rst_outstanding"}, obs_outs[d], 0);
   endtask

   // One clock cycle on instance d: drive, compare all outputs, advance model.
   // The locked channel's command is held unchanged until it is accepted.
   task automatic step(input int d, input bit [7:0] rd, input bit [7:0] wr,
                       input bit waitreq, input int rid);
      int       g, n;
      bit       e_rd, e_wr, accept, inc, dec;
      bit [7:0] e_wait, e_rv;
      string    p = d ? "b" : "a";
      n = cfg_n[d];
      @(posedge clock);
      #1;
      for (int i = 0; i < n; i++) begin
         if (i != m_lock[d]) begin
            cur_rd[d][i]    = rd[i];
            cur_wr[d][i]    = wr[i];
            cur_addr[d][i]  = AW'($urandom);
            cur_wdata[d][i] = $urandom;
            cur_mask[d][i]  = MW'($urandom);
         end
      end
      cur_wait[d]  = waitreq;
      cur_rid[d]   = 3'(rid);
      cur_rdata[d] = $urandom;
      #1;
      g      = ref_grant(d);
      e_wr   = (g >= 0) && cur_wr[d][g];
      e_rd   = (g >= 0) && cur_rd[d][g] && !cur_wr[d][g];
      e_wait = '0;
      for (int i = 0; i < n; i++) e_wait[i] = (i == g) ? waitreq : 1'b1;
      e_rv = '0;
      if (rid >= 1 && rid <= n) e_rv[rid-1] = 1'b1;

      check_eq({p, "_mem_read"}, obs_mrd[d], e_rd);
      check_eq({p, "_mem_write"}, obs_mwr[d], e_wr);
      check_eq({p, "_mem_id"}, obs_id[d], g + 1);
      check_eq({p, "_ch_wait"}, obs_wait[d], e_wait);
      check_eq({p, "_rvalid"}, obs_rv[d], e_rv);
      check_eq({p, "_rdata"}, obs_rdata[d], cur_rdata[d]);
      check_eq({p, "_outstanding"}, obs_outs[d], m_out[d]);
      if (g >= 0) begin
         check_eq({p, "_mem_addr"}, obs_addr[d], cur_addr[d][g]);
         check_eq({p, "_mem_wdata"}, obs_wdata[d], cur_wdata[d][g]);
         check_eq({p, "_mem_mask"}, obs_mask[d], cur_mask[d][g]);
      end

      accept = (g >= 0) && !waitreq;
      if (cfg_rr[d] && accept) m_ptr[d] = (g + 1) % n;
      m_lock[d] = ((g >= 0) && waitreq) ? g : -1;
      inc = accept && e_rd;
      dec = (rid >= 1) && (rid <= n) && (m_out[d] > 0);
      if (inc && !dec) m_out[d]++;
      else if (dec && !inc) m_out[d]--;
   endtask

   // Reset pulse that starts with the current commands still applied, so the
   // idle checks show the outputs are forced while rst is high.
   task automatic do_reset();
      @(posedge clock);
      #1;
      rst = 1'b1;
      #1;
      check_idle(0);
      check_idle(1);
      @(posedge clock);
      #1;
      clear_inputs();
      model_reset();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      model_reset();
      cur_rd[0] = 8'hff;
      cur_rd[1] = 8'hff;
      cur_wr[1] = 8'hff;
      #1 rst = 1'b1;
      #1;
      check_idle(0);
      check_idle(1);
      @(posedge clock);
      #1;
      clear_inputs();
      rst = 1'b0;

      // Fixed priority: both read, ch0 wins
      step(0, 8'b11, 8'b00, 1'b0, 0);
      check_eq("a_prio_id", obs_id[0], 1);
      check_eq("a_prio_wait", obs_wait[0], 8'b10);
      do_reset();

      // Lock: ch1 stalled three cycles, then ch0 raised
      step(0, 8'b10, 8'b00, 1'b1, 0);
      step(0, 8'b10, 8'b00, 1'b1, 0);
      step(0, 8'b10, 8'b00, 1'b1, 0);
      check_eq("a_lock_id_c3", obs_id[0], 2);
      step(0, 8'b11, 8'b00, 1'b1, 0);
      check_eq("a_lock_id_ch0_up", obs_id[0], 2);
      step(0, 8'b11, 8'b00, 1'b0, 0);
      check_eq("a_lock_id_accept", obs_id[0], 2);
      step(0, 8'b11, 8'b00, 1'b0, 0);
      check_eq("a_lock_id_after", obs_id[0], 1);
      do_reset();

      // Read limit: two reads in flight block ch0, a write from ch1 still goes
      step(0, 8'b01, 8'b00, 1'b0, 0);
      step(0, 8'b01, 8'b00, 1'b0, 0);
      step(0, 8'b01, 8'b10, 1'b0, 0);
      check_eq("a_lim_ch0_wait", obs_wait[0][0], 1);
      check_eq("a_lim_write", obs_mwr[0], 1);
      check_eq("a_lim_id", obs_id[0], 2);
      step(0, 8'b01, 8'b00, 1'b0, 1);
      check_eq("a_lim_ret_wait", obs_wait[0][0], 1);
      step(0, 8'b01, 8'b00, 1'b0, 0);
      check_eq("a_lim_outs_1", obs_outs[0], 1);
      check_eq("a_lim_read_go", obs_mrd[0], 1);

      // Return routing: tag 2 routes to ch1, tag 5 is ignored
      step(0, 8'b00, 8'b00, 1'b0, 2);
      check_eq("a_ret2_valid", obs_rv[0], 8'b10);
      check_eq("a_ret2_outs", obs_outs[0], 2);
      step(0, 8'b00, 8'b00, 1'b0, 5);
      check_eq("a_ret5_valid", obs_rv[0], 0);
      step(0, 8'b00, 8'b00, 1'b0, 0);
      check_eq("a_ret5_outs", obs_outs[0], 1);
      do_reset();

      // Random traffic on the fixed-priority instance
      for (int c = 0; c < 300; c++) begin
         step(0, 8'($urandom), 8'($urandom & $urandom), $urandom_range(0, 3) == 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0);
      end
      do_reset();

      // Round-robin: all three write continuously
      for (int k = 0; k < 6; k++) begin
         step(1, 8'b000, 8'b111, 1'b0, 0);
         check_eq($sformatf("b_rr_id%0d", k), obs_id[1], (k % 3) + 1);
      end
      do_reset();

      // Random traffic on the round-robin instance
      for (int c = 0; c < 400; c++) begin
         step(1, 8'($urandom), 8'($urandom & $urandom), $urandom_range(0, 3) == 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0);
      end
      do_reset();

      // Asynchronous reset while locked with three reads in flight
      step(1, 8'b001, 8'b000, 1'b0, 0);
      step(1, 8'b001, 8'b000, 1'b0, 0);
      step(1, 8'b001, 8'b000, 1'b0, 0);
      step(1, 8'b010, 8'b000, 1'b1, 0);
      step(1, 8'b011, 8'b000, 1'b1, 0);
      check_eq("b_prerst_outs", obs_outs[1], 3);
      check_eq("b_prerst_id", obs_id[1], 2);
      #1;
      rst = 1'b1;
      #1;
      check_idle(1);
      @(posedge clock);
      #1;
      clear_inputs();
      model_reset();
      rst = 1'b0;
      step(1, 8'b000, 8'b111, 1'b0, 0);
      check_eq("b_postrst_ptr_id", obs_id[1], 1);
      do_reset();
      step(1, 8'b000, 8'b000, 1'b0, 2);
      check_eq("b_postrst_rvalid", obs_rv[1], 8'b010);
      step(1, 8'b000, 8'b000, 1'b0, 0);
      check_eq("b_postrst_outs", obs_outs[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL have parameter N, default 2, number of requester channels (2..7).
REQ-002 SHALL have parameter AW, default 30, word-address width.
REQ-003 SHALL have parameter DW, default 32, data width; mask width is DW/8.
REQ-004 SHALL have parameter IDW, default 3, id width; it must satisfy 2**IDW > N.
REQ-005 SHALL have parameter RR, default 0: 0 selects fixed priority, 1 selects round-robin.
REQ-006 SHALL have parameter MAX_OUT, default 4, maximum number of outstanding reads (1..15).
REQ-007 SHALL have ports, in this order:
- clock  in  1  sole clock.
- rst  in  1  reset; asynchronous, active-high.
- ch_read  in  N  per-channel read strobe.
- ch_write  in  N  per-channel write strobe.
- ch_address  in  N*AW  per-channel address; channel i occupies slice i.
- ch_writedata  in  N*DW  per-channel write data.
- ch_writedatamask  in  N*DW/8  per-channel byte mask.
- ch_waitrequest  out  N  per-channel stall.
- ch_readdata  out  DW  shared read-return data.
- ch_readdatavalid  out  N  per-channel read-return strobe.
- mem_waitrequest  in  1  memory stall.
- mem_id  out  IDW  tag of the current command.
- mem_address  out  AW  command address.
- mem_read  out  1  command read strobe.
- mem_write  out  1  command write strobe.
- mem_writedata  out  DW  command write data.
- mem_writedatamask  out  DW/8  command byte mask.
- mem_readdata  in  DW  returned read data.
- mem_readdataid  in  IDW  tag of returned data; 0 means none.
- outstanding  out  4  current count of outstanding reads.

Function
REQ-008 SHALL tag channel i with id i+1; id 0 SHALL never be issued.
REQ-009 SHALL treat channel i as requesting when ch_read[i] | ch_write[i] is high.
REQ-010 SHALL treat a read request as blocked when outstanding == MAX_OUT; a blocked read is not eligible for grant, and a write is never blocked.
REQ-011 SHALL, in fixed mode, grant the lowest-index eligible requester.
REQ-012 SHALL, in round-robin mode, grant the first eligible requester searching from rr_ptr upward, wrapping from N-1 to 0.
REQ-013 SHALL drive all mem_* command outputs combinationally from the granted channel, with zero-cycle latency.
REQ-014 SHALL drive mem_read, mem_write and mem_id to 0 when no channel is granted; mem_address and mem_writedata are then don't-care.
REQ-015 SHALL define acceptance as: grant present & ~mem_waitrequest.
REQ-016 SHALL drive ch_waitrequest[g] = mem_waitrequest for the granted channel g, and 1 for every other channel.
REQ-017 SHALL lock the grant when a granted command sees mem_waitrequest high: the locked channel keeps the grant on every following cycle until acceptance, regardless of priority.
REQ-018 SHALL release the lock in the cycle after acceptance.
REQ-019 SHALL, on each acceptance in round-robin mode, set rr_ptr to g+1 modulo N; fixed mode SHALL never update rr_ptr.
REQ-020 SHALL keep the locked channel's command in force, unaltered, until acceptance; the arbiter does not check this, and the bench does.
REQ-021 SHALL count outstanding reads as follows:
- increment on an accepted read;
- decrement when mem_readdataid is in 1..N;
- leave the count unchanged when both occur in the same cycle.
REQ-022 SHALL saturate the count at 0: a return arriving while outstanding == 0 does not decrement.
REQ-023 SHALL pass ch_readdata = mem_readdata unconditionally.
REQ-024 SHALL assert ch_readdatavalid[i] iff mem_readdataid == i+1, combinationally; an id above N SHALL be ignored and SHALL NOT change the count.
REQ-025 SHALL grant a write when a channel asserts both read and write, issuing mem_write=1 and mem_read=0.

Reset
REQ-026 SHALL, on rst, asynchronously clear the lock, set rr_ptr to 0 and set outstanding to 0.
REQ-027 SHALL, while rst is high, hold mem_read=0, mem_write=0, mem_id=0 and ch_waitrequest all-ones.
REQ-028 SHALL, on reset mid-transfer, discard the pending command and the outstanding count; returns arriving after reset SHALL still pulse ch_readdatavalid but SHALL NOT decrement below 0.

Verification
REQ-029 SHALL cover fixed priority: N=2, ch0 and ch1 both read, mem_waitrequest=0 -> mem_id=1, ch_waitrequest=2'b10.
REQ-030 SHALL cover lock: grant ch1 while mem_waitrequest=1 for 3 cycles, then raise ch0 -> mem_id stays 2 until acceptance, then becomes 1 on the next cycle.
REQ-031 SHALL cover round-robin: RR=1, N=3, all three channels write continuously -> accepted ids run 1,2,3,1,2,3.
REQ-032 SHALL cover the read limit: MAX_OUT=2, two reads accepted with no returns -> a third read sees ch_waitrequest=1 while a concurrent write from another channel is accepted; mem_readdataid=1 -> outstanding=1 and the read proceeds.
REQ-033 SHALL cover return routing: mem_readdataid=2 -> ch_readdatavalid=2'b10; mem_readdataid=5 with N=2 -> no valid and the count is unchanged.
REQ-034 SHALL cover async reset: assert rst mid-lock with outstanding=3 -> outputs idle immediately; after release outstanding=0 and rr_ptr=0.
